// File: rtl/fec_lock_ctrl.sv
// fec_lock_ctrl: frame-lock controller for the FEC receive path.
// Walks candidate block alignments with one-bit SLIP requests until LOCK_GOOD
// consecutive zero-syndrome frames are seen, then holds FEC_LOCK until
// UNLOCK_BAD consecutive uncorrectable frames arrive. Saturating statistics
// counters are kept for CSR readout.
module fec_lock_ctrl #(
    parameter int LOCK_GOOD      = 4,
    parameter int UNLOCK_BAD     = 8,
    parameter int HOLDOFF_FRAMES = 2,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             SYND_VAL,
    input  logic             SYND_ZERO,
    input  logic             CORRECTABLE,
    input  logic             CNT_CLR,
    output logic             FEC_LOCK,
    output logic             SLIP,
    output logic [2:0]       LOCK_STATE,
    output logic [CNT_W-1:0] CORR_CNT,
    output logic [CNT_W-1:0] UNCORR_CNT,
    output logic [CNT_W-1:0] SLIP_CNT,
    output logic [CNT_W-1:0] LOSS_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TEST   = 3'd1,
        ST_SLIP   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
    localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_BAD - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_FRAMES);

    state_t            state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic [BAD_W-1:0]  bad_cnt, bad_nxt;
    logic [HOLD_W-1:0] holdoff_cnt, holdoff_nxt;
    logic              inc_corr, inc_uncorr, inc_slip, inc_loss;

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Next-state, FSM counters and statistic increment strobes.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can leave it unassigned and infer a latch.
        state_nxt   = state;
        good_nxt    = good_cnt;
        bad_nxt     = bad_cnt;
        holdoff_nxt = holdoff_cnt;
        inc_corr    = 1'b0;
        inc_uncorr  = 1'b0;
        inc_loss    = 1'b0;
        // The SLIP pulse is on the wire for this cycle whatever ENABLE does.
        inc_slip    = (state == ST_SLIP);

        if (!ENABLE) begin
            // Disable beats any frame verdict; that frame's stats are dropped.
            state_nxt = ST_IDLE;
            good_nxt  = '0;
            bad_nxt   = '0;
            inc_loss  = (state == ST_LOCKED);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_TEST;
                    good_nxt  = '0;
                end
                ST_TEST: begin
                    if (SYND_VAL) begin
                        if (SYND_ZERO) begin
                            if (good_cnt == GOOD_LAST) begin
                                state_nxt = ST_LOCKED;
                                good_nxt  = '0;
                                bad_nxt   = '0;
                            end else begin
                                good_nxt = good_cnt + 1'b1;
                            end
                        end else begin
                            // Any nonzero syndrome rejects this alignment.
                            state_nxt = ST_SLIP;
                            good_nxt  = '0;
                        end
                    end
                end
                ST_SLIP: begin
                    // A frame arriving here is stale and is not counted.
                    if (HOLDOFF_FRAMES == 0) begin
                        state_nxt = ST_TEST;
                        good_nxt  = '0;
                    end else begin
                        state_nxt   = ST_HOLD;
                        holdoff_nxt = HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    if (SYND_VAL) begin
                        holdoff_nxt = holdoff_cnt - 1'b1;
                        if (holdoff_cnt <= HOLD_W'(1)) begin
                            state_nxt = ST_TEST;
                            good_nxt  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (SYND_VAL) begin
                        if (SYND_ZERO) begin
                            bad_nxt = '0;
                        end else if (CORRECTABLE) begin
                            bad_nxt  = '0;
                            inc_corr = 1'b1;
                        end else begin
                            inc_uncorr = 1'b1;
                            if (bad_cnt == BAD_LAST) begin
                                state_nxt = ST_SLIP;
                                bad_nxt   = '0;
                                inc_loss  = 1'b1;
                            end else begin
                                bad_nxt = bad_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    good_nxt  = '0;
                    bad_nxt   = '0;
                end
            endcase
        end
    end

    // State, FSM counters and registered status outputs.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (RST) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            holdoff_cnt <= '0;
            FEC_LOCK    <= 1'b0;
            SLIP        <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            bad_cnt     <= bad_nxt;
            holdoff_cnt <= holdoff_nxt;
            FEC_LOCK    <= (state_nxt == ST_LOCKED);
            SLIP        <= (state_nxt == ST_SLIP);
        end
    end

    assign LOCK_STATE = state;

    // Statistics counters: saturate at all-ones; clear beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RST || CNT_CLR) begin
            CORR_CNT   <= '0;
            UNCORR_CNT <= '0;
            SLIP_CNT   <= '0;
            LOSS_CNT   <= '0;
        end else begin
            CORR_CNT   <= sat_inc(CORR_CNT, inc_corr);
            UNCORR_CNT <= sat_inc(UNCORR_CNT, inc_uncorr);
            SLIP_CNT   <= sat_inc(SLIP_CNT, inc_slip);
            LOSS_CNT   <= sat_inc(LOSS_CNT, inc_loss);
        end
    end

endmodule

// File: tb/tb_fec_lock_ctrl.sv
// Scoreboard bench for fec_lock_ctrl. The driver pushes the expected output
// snapshot for the cycle after each stimulus edge; the monitor pops and
// compares snapshots as their cycle comes up.
module tb_fec_lock_ctrl;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ENABLE = 1'b0;
    logic             SYND_VAL = 1'b0;
    logic             SYND_ZERO = 1'b0;
    logic             CORRECTABLE = 1'b0;
    logic             CNT_CLR = 1'b0;
    logic             FEC_LOCK;
    logic             SLIP;
    logic [2:0]       LOCK_STATE;
    logic [CNT_W-1:0] CORR_CNT, UNCORR_CNT, SLIP_CNT, LOSS_CNT;

    fec_lock_ctrl #(
        .LOCK_GOOD(4), .UNLOCK_BAD(8), .HOLDOFF_FRAMES(2), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .SYND_VAL(SYND_VAL),
        .SYND_ZERO(SYND_ZERO), .CORRECTABLE(CORRECTABLE), .CNT_CLR(CNT_CLR),
        .FEC_LOCK(FEC_LOCK), .SLIP(SLIP), .LOCK_STATE(LOCK_STATE),
        .CORR_CNT(CORR_CNT), .UNCORR_CNT(UNCORR_CNT), .SLIP_CNT(SLIP_CNT),
        .LOSS_CNT(LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int               cyc;
        string            name;
        logic             lock;
        logic             slip;
        logic [2:0]       st;
        logic [CNT_W-1:0] corr, uncorr, slips, loss;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        n_checks++;
        if (e.cyc != cyc || FEC_LOCK !== e.lock || SLIP !== e.slip || LOCK_STATE !== e.st ||
            CORR_CNT !== e.corr || UNCORR_CNT !== e.uncorr || SLIP_CNT !== e.slips ||
            LOSS_CNT !== e.loss) begin
            n_fail++;
            $display("FAIL %s @cyc %0d (due %0d): got lock=%0b slip=%0b st=%0d corr=%0d uncorr=%0d slips=%0d loss=%0d; want lock=%0b slip=%0b st=%0d corr=%0d uncorr=%0d slips=%0d loss=%0d",
                     e.name, cyc, e.cyc, FEC_LOCK, SLIP, LOCK_STATE, CORR_CNT, UNCORR_CNT, SLIP_CNT, LOSS_CNT,
                     e.lock, e.slip, e.st, e.corr, e.uncorr, e.slips, e.loss);
        end
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) check(q.pop_front());
    end

    // Drive one cycle of inputs at the falling edge; the next rising edge samples them.
    task automatic drive(input logic rst, en, val, zero, corr, clr);
        @(negedge CLK);
        RST = rst; ENABLE = en; SYND_VAL = val; SYND_ZERO = zero;
        CORRECTABLE = corr; CNT_CLR = clr;
    endtask

    task automatic frame(input logic zero, corr, input logic clr = 1'b0);
        drive(1'b0, 1'b1, 1'b1, zero, corr, clr);
    endtask

    task automatic idle(input logic en = 1'b1, input logic clr = 1'b0);
        drive(1'b0, en, 1'b0, 1'b0, 1'b0, clr);
    endtask

    // Expected outputs after the edge that samples the inputs just driven.
    task automatic expect_out(input string name, input logic lock, slip, input logic [2:0] st,
                              input int corr, uncorr, slips, loss);
        exp_t e;
        e.cyc = cyc + 1; e.name = name; e.lock = lock; e.slip = slip; e.st = st;
        e.corr = CNT_W'(corr); e.uncorr = CNT_W'(uncorr);
        e.slips = CNT_W'(slips); e.loss = CNT_W'(loss);
        q.push_back(e);
    endtask

    initial begin
        // Reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);

        // Lock acquisition
        idle();                   expect_out("idle_to_test", 0, 0, 1, 0, 0, 0, 0);
        repeat (3) frame(1, 0);   expect_out("pre_lock", 0, 0, 1, 0, 0, 0, 0);
        frame(1, 0);              expect_out("lock_acq", 1, 0, 4, 0, 0, 0, 0);

        // Correctable retention: alternate uncorrectable / correctable
        for (int i = 0; i < 20; i++) begin
            frame(0, logic'(i % 2));
            if (i == 0) expect_out("first_uncorr", 1, 0, 4, 0, 1, 0, 0);
        end
        expect_out("corr_retain", 1, 0, 4, 10, 10, 0, 0);
        frame(0, 1, 1);           expect_out("clr_wins", 1, 0, 4, 0, 0, 0, 0);

        // Lock loss: 7 bad, 1 good, 8 bad
        repeat (7) frame(0, 0);   expect_out("bad7_held", 1, 0, 4, 0, 7, 0, 0);
        frame(1, 0);              expect_out("good_resets", 1, 0, 4, 0, 7, 0, 0);
        repeat (7) frame(0, 0);   expect_out("bad14_held", 1, 0, 4, 0, 14, 0, 0);
        frame(0, 0);              expect_out("lock_lost", 0, 1, 2, 0, 15, 0, 1);
        frame(0, 0);              expect_out("slip_frame_drop", 0, 0, 3, 0, 15, 1, 1);
        frame(0, 0);              expect_out("hold_1", 0, 0, 3, 0, 15, 1, 1);
        frame(0, 0);              expect_out("hold_done", 0, 0, 1, 0, 15, 1, 1);

        // Slip from TEST, holdoff ignores bad frames, then relock
        frame(1, 0); frame(1, 0);
        frame(0, 1);              expect_out("test_bad_slip", 0, 1, 2, 0, 15, 1, 1);
        idle();                   expect_out("slip_pulse_end", 0, 0, 3, 0, 15, 2, 1);
        frame(0, 0); frame(0, 0); expect_out("holdoff_ignored", 0, 0, 1, 0, 15, 2, 1);
        repeat (3) frame(1, 0);   expect_out("relock_pre", 0, 0, 1, 0, 15, 2, 1);
        frame(1, 0);              expect_out("relock", 1, 0, 4, 0, 15, 2, 1);

        // ENABLE drop while LOCKED, with a correctable frame that must not count
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("enable_drop", 0, 0, 0, 0, 15, 2, 2);
        idle(0);                  expect_out("idle_stays", 0, 0, 0, 0, 15, 2, 2);

        // RST during HOLD
        idle();                   expect_out("reenable", 0, 0, 1, 0, 15, 2, 2);
        frame(0, 0);              expect_out("slip_again", 0, 1, 2, 0, 15, 2, 2);
        idle();                   expect_out("hold_pre_rst", 0, 0, 3, 0, 15, 3, 2);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("rst_in_hold", 0, 0, 0, 0, 0, 0, 0);

        // Saturation of SLIP_CNT at 15 over 20 slips
        idle();                   expect_out("sat_start", 0, 0, 1, 0, 0, 0, 0);
        for (int s = 1; s <= 20; s++) begin
            frame(0, 0); idle(); frame(0, 0); frame(0, 0);
            if (s == 15) expect_out("slip_15", 0, 0, 1, 0, 0, 15, 0);
        end
        expect_out("slip_sat", 0, 0, 1, 0, 0, 15, 0);

        // CNT_CLR coincident with the SLIP cycle
        frame(0, 0);              expect_out("slip_at_sat", 0, 1, 2, 0, 0, 15, 0);
        idle(1, 1);               expect_out("clr_on_slip", 0, 0, 3, 0, 0, 0, 0);

        idle(); idle(); idle();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fec_lock_ctrl.md
Name: fec_lock_ctrl

Overview:
- Frame-lock controller for the Clause-74-style FEC receive path.
- Consumes per-frame syndrome verdicts from the syndrome/parity engine and walks the candidate alignment by issuing one-bit SLIP requests to the gearbox.
- Declares and withdraws FEC_LOCK, which gates the write/read sequencing and buffer flush of the downstream correction stage.
- Keeps saturating correction/uncorrectable/slip/lock-loss statistics for CSR readout.

Parameters:
LOCK_GOOD, 4, consecutive zero-syndrome frames required in TEST to declare lock
UNLOCK_BAD, 8, consecutive uncorrectable frames in LOCKED that drop lock
HOLDOFF_FRAMES, 2, SYND_VAL pulses discarded after each slip (stale frames in the syndrome pipeline)
CNT_W, 16, width of each statistics counter

Ports:
CLK  input  1  core clock
RST  input  1  reset, synchronous, active-high
ENABLE  input  1  lock search enable; low forces IDLE
SYND_VAL  input  1  one-cycle pulse, one per completed FEC frame
SYND_ZERO  input  1  frame syndrome is zero; qualified by SYND_VAL
CORRECTABLE  input  1  nonzero syndrome within burst-correction capability; qualified by SYND_VAL
CNT_CLR  input  1  synchronous clear of all statistics counters
FEC_LOCK  output  1  frame lock achieved (registered)
SLIP  output  1  one-cycle request to shift block alignment by one bit
LOCK_STATE  output  3  encoded FSM state for CSR
CORR_CNT  output  CNT_W  frames corrected while locked
UNCORR_CNT  output  CNT_W  uncorrectable frames while locked
SLIP_CNT  output  CNT_W  slips issued
LOSS_CNT  output  CNT_W  LOCKED-to-unlocked transitions

Behaviour:
- Reset: state IDLE; FEC_LOCK=0, SLIP=0, LOCK_STATE=0; good_cnt, bad_cnt, holdoff_cnt and all stats cleared.
- States and encodings: IDLE=0, TEST=1, SLIP=2, HOLD=3, LOCKED=4. All outputs are registered. FEC_LOCK = (state==LOCKED). SLIP = (state==SLIP). LOCK_STATE = state.
- Global rule: ENABLE=0 in any state -> IDLE next cycle; good_cnt and bad_cnt cleared. If leaving LOCKED this way, LOSS_CNT increments.
- IDLE: ENABLE=1 -> TEST, good_cnt=0.
- TEST, on SYND_VAL:
  - SYND_ZERO=1: good_cnt++. If good_cnt was LOCK_GOOD-1 -> LOCKED, bad_cnt=0.
  - SYND_ZERO=0 (CORRECTABLE ignored) -> SLIP, good_cnt=0.
  - FEC_LOCK rises in the cycle after the edge that samples the final good SYND_VAL.
- SLIP:
  - Occupies exactly one cycle; SLIP high for that cycle only; SLIP_CNT++.
  - Next state HOLD, holdoff_cnt=HOLDOFF_FRAMES.
  - A SYND_VAL arriving in this cycle is discarded and does not count toward holdoff.
- HOLD:
  - Each SYND_VAL decrements holdoff_cnt, and its verdict is discarded. The pulse that brings the count to 0 -> TEST, good_cnt=0.
  - HOLDOFF_FRAMES=0 -> go straight to TEST the cycle after SLIP.
- LOCKED, on SYND_VAL:
  - SYND_ZERO=1: bad_cnt=0.
  - SYND_ZERO=0 & CORRECTABLE=1: bad_cnt=0, CORR_CNT++.
  - SYND_ZERO=0 & CORRECTABLE=0: UNCORR_CNT++, bad_cnt++. If bad_cnt was UNLOCK_BAD-1 -> SLIP, LOSS_CNT++, and FEC_LOCK falls the next cycle.
  - A correctable frame counts as good for lock retention.
- Counters:
  - All four saturate at 2^CNT_W-1; no wrap.
  - CNT_CLR wins over a same-cycle increment, i.e. the counter is 0 the next cycle.
  - CNT_CLR does not affect FSM counters or state.
- Simultaneous events:
  - ENABLE=0 overrides any SYND_VAL transition in the same cycle. Stats from that SYND_VAL are not counted.
  - RST overrides everything, including mid-LOCKED and mid-HOLD.
- CORRECTABLE with SYND_ZERO=1 is treated as SYND_ZERO (zero syndrome takes priority).
- SYND_VAL back-to-back on consecutive cycles must be handled; each pulse is one frame.

Test Plan:
- Lock acquisition: ENABLE=1, then 4 SYND_VAL pulses with SYND_ZERO=1 -> FEC_LOCK=1 one cycle after the 4th; SLIP never asserted; LOCK_STATE=4.
- Slip and holdoff: in TEST, 2 good frames then 1 bad -> SLIP high exactly 1 cycle, SLIP_CNT=1. The next 2 SYND_VAL are ignored even if bad. Then 4 good -> lock.
- Lock loss: LOCKED, then 7 uncorrectable, 1 good, then 8 uncorrectable -> lock held through the first 7. After the 8th of the second run, FEC_LOCK=0, SLIP pulse, LOSS_CNT=1, UNCORR_CNT=15.
- Correctable retention: LOCKED, then 20 frames alternating uncorrectable and correctable -> FEC_LOCK stays 1, CORR_CNT=10, UNCORR_CNT=10.
- ENABLE/RST mid-operation: drop ENABLE while LOCKED -> IDLE next cycle, FEC_LOCK=0, LOSS_CNT++. Assert RST during HOLD -> all outputs and counters 0.
- Saturation/clear: with CNT_W=4 override, 20 slips -> SLIP_CNT=15. CNT_CLR coincident with a SLIP cycle -> SLIP_CNT=0.
